// File: rtl/wm_pkg.sv
// wm_pkg: shared state encoding, fault codes and timer width for the washing-machine controller
package wm_pkg;
  localparam int TIMER_W_DEF = 16;
  typedef enum logic [3:0] {
    ST_START = 4'd0,
    ST_READY = 4'd1,
    ST_FILL  = 4'd2,
    ST_HEAT  = 4'd3,
    ST_WASH  = 4'd4,
    ST_RINSE = 4'd5,
    ST_SPIN  = 4'd6,
    ST_PAUSE = 4'd7,
    ST_FAULT = 4'd8
  } state_t;
  localparam logic [2:0] FC_NONE  = 3'd0;
  localparam logic [2:0] FC_FILL  = 3'd1;
  localparam logic [2:0] FC_HEAT  = 3'd2;
  localparam logic [2:0] FC_IMBAL = 3'd3;
  localparam logic [2:0] FC_MOTOR = 3'd4;
  function automatic logic is_timed(input state_t s);
    return s inside {ST_FILL, ST_HEAT, ST_WASH, ST_RINSE, ST_SPIN, ST_FAULT};
  endfunction
endpackage

// File: rtl/wm_phase_timer.sv
// wm_phase_timer: loadable down-counter that saturates at zero and flags expiry
module wm_phase_timer #(
  parameter int TIMER_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               enable,
  output logic               expired
);
  logic [TIMER_W-1:0] count;
  // load has priority; counting stops at zero so expiry stays asserted
  always_ff @(posedge clock or posedge reset) begin
    if (reset) count <= '0;
    else if (load) count <= load_val;
    else if (enable && count != '0) count <= count - 1'b1;
  end
  assign expired = count == '0;
endmodule

// File: rtl/wm_cycle_controller.sv
// wm_cycle_controller: coin-to-spin washing cycle FSM with pause, latched faults and pulses
module wm_cycle_controller
  import wm_pkg::*;
#(
  parameter int TIMER_W      = TIMER_W_DEF,
  parameter int FILL_TIMEOUT = 1000,
  parameter int HEAT_TIMEOUT = 2000,
  parameter int WASH_CYCLES  = 500,
  parameter int RINSE_CYCLES = 300,
  parameter int NUM_RINSES   = 2,
  parameter int SPIN_CYCLES  = 200,
  parameter int FAULT_HOLD   = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sig_Coin,
  input  logic       sig_Cancel,
  input  logic       sig_Lid_Closed,
  input  logic       sig_Full,
  input  logic       sig_Temperature,
  input  logic       sig_Out_Of_Balance,
  input  logic       sig_Motor_Failure,
  input  logic       sig_Fault_Ack,
  output logic       start,
  output logic       ready,
  output logic       fill_Water_Operation,
  output logic       heat_Water_Operation,
  output logic       wash_Operation,
  output logic       rinse_Operation,
  output logic       spin_Operation,
  output logic       fault,
  output logic       paused,
  output logic       water_Intake,
  output logic       coin_Return,
  output logic       cycle_Done,
  output logic       fault_Cleared,
  output logic [2:0] fault_Code,
  output logic [3:0] rinse_Count,
  output logic [3:0] state
);
  localparam logic [TIMER_W-1:0] FILL_LD  = TIMER_W'(FILL_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] HEAT_LD  = TIMER_W'(HEAT_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] WASH_LD  = TIMER_W'(WASH_CYCLES - 1);
  localparam logic [TIMER_W-1:0] RINSE_LD = TIMER_W'(RINSE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] SPIN_LD  = TIMER_W'(SPIN_CYCLES - 1);
  localparam logic [TIMER_W-1:0] HOLD_LD  = TIMER_W'(FAULT_HOLD - 1);
  state_t st, nxt, saved, nxt_saved;
  logic [2:0] nxt_code, fc;
  logic [3:0] nxt_rinse;
  logic [TIMER_W-1:0] ld_val;
  logic ld, fin, expired, last_rinse, ret_d, done_d, clr_d;
  wm_phase_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (ld),
    .load_val (ld_val),
    .enable   (is_timed(st)),
    .expired  (expired)
  );
  assign last_rinse = (rinse_Count + 4'd1) == 4'(NUM_RINSES);
  // per-phase fault source and completion condition for the active phases
  always_comb begin
    fc = FC_NONE;
    fin = 1'b0;
    case (st)
      ST_FILL: begin
        fc = expired ? FC_FILL : FC_NONE;
        fin = sig_Full;
      end
      ST_HEAT: begin
        fc = expired ? FC_HEAT : FC_NONE;
        fin = sig_Temperature;
      end
      ST_WASH: begin
        fc = sig_Out_Of_Balance ? FC_IMBAL : FC_NONE;
        fin = expired;
      end
      ST_RINSE: begin
        fc = sig_Motor_Failure ? FC_MOTOR : FC_NONE;
        fin = expired;
      end
      ST_SPIN: begin
        fc = sig_Motor_Failure ? FC_MOTOR : sig_Out_Of_Balance ? FC_IMBAL : FC_NONE;
        fin = expired;
      end
      default: ;
    endcase
  end
  // next state, timer loads and pulse requests; fault beats lid-open beats completion
  always_comb begin
    nxt = st;
    nxt_saved = saved;
    nxt_code = fault_Code;
    nxt_rinse = rinse_Count;
    ld = 1'b0;
    ld_val = '0;
    ret_d = 1'b0;
    done_d = 1'b0;
    clr_d = 1'b0;
    case (st)
      ST_START: nxt = sig_Coin ? ST_READY : ST_START;
      ST_READY:
        if (sig_Cancel) begin
          nxt = ST_START;
          ret_d = 1'b1;
        end else if (sig_Lid_Closed) begin
          nxt = ST_FILL;
          nxt_rinse = '0;
          ld = 1'b1;
          ld_val = FILL_LD;
        end
      ST_FILL, ST_HEAT, ST_WASH, ST_RINSE, ST_SPIN:
        if (fc != FC_NONE) begin
          nxt = ST_FAULT;
          nxt_code = fc;
          ld = 1'b1;
          ld_val = HOLD_LD;
        end else if (!sig_Lid_Closed) begin
          nxt = ST_PAUSE;
          nxt_saved = st;
        end else if (fin) begin
          ld = st != ST_SPIN;
          case (st)
            ST_FILL: begin
              nxt = ST_HEAT;
              ld_val = HEAT_LD;
            end
            ST_HEAT: begin
              nxt = ST_WASH;
              ld_val = WASH_LD;
            end
            ST_WASH: begin
              nxt = ST_RINSE;
              ld_val = RINSE_LD;
            end
            ST_RINSE: begin
              nxt_rinse = rinse_Count + 4'd1;
              nxt = last_rinse ? ST_SPIN : ST_RINSE;
              ld_val = last_rinse ? SPIN_LD : RINSE_LD;
            end
            default: begin
              nxt = ST_READY;
              done_d = 1'b1;
            end
          endcase
        end
      ST_PAUSE:
        if (sig_Cancel) begin
          nxt = ST_START;
          nxt_rinse = '0;
        end else if (sig_Lid_Closed) nxt = saved;
      ST_FAULT:
        if (expired && sig_Fault_Ack) begin
          nxt = ST_READY;
          nxt_code = FC_NONE;
          clr_d = 1'b1;
        end
      default: nxt = ST_START;
    endcase
  end
  // state, saved phase, latched code, rinse counter and registered pulses
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st <= ST_START;
      saved <= ST_START;
      fault_Code <= FC_NONE;
      rinse_Count <= '0;
      coin_Return <= 1'b0;
      cycle_Done <= 1'b0;
      fault_Cleared <= 1'b0;
    end else begin
      st <= nxt;
      saved <= nxt_saved;
      fault_Code <= nxt_code;
      rinse_Count <= nxt_rinse;
      coin_Return <= ret_d;
      cycle_Done <= done_d;
      fault_Cleared <= clr_d;
    end
  end
  assign state = st;
  assign start = st == ST_START;
  assign ready = st == ST_READY;
  assign fill_Water_Operation = st == ST_FILL;
  assign heat_Water_Operation = st == ST_HEAT;
  assign wash_Operation = st == ST_WASH;
  assign rinse_Operation = st == ST_RINSE;
  assign spin_Operation = st == ST_SPIN;
  assign fault = st == ST_FAULT;
  assign paused = st == ST_PAUSE;
  assign water_Intake = st == ST_FILL || st == ST_RINSE;
endmodule

// File: tb/tb_wm_cycle_controller.sv
// tb_wm_cycle_controller: scoreboard bench with a phase/elapsed-cycle reference model
module tb_wm_cycle_controller;
  localparam int FILL_T = 5, HEAT_T = 7, WASH_T = 10, RINSE_T = 4, NRINSE = 2, SPIN_T = 4, HOLD = 8;
  logic clock = 1'b0, reset = 1'b1;
  logic sig_Coin = 0, sig_Cancel = 0, sig_Lid_Closed = 0, sig_Full = 0, sig_Temperature = 0;
  logic sig_Out_Of_Balance = 0, sig_Motor_Failure = 0, sig_Fault_Ack = 0;
  logic start, ready, fill_Water_Operation, heat_Water_Operation, wash_Operation;
  logic rinse_Operation, spin_Operation, fault, paused, water_Intake;
  logic coin_Return, cycle_Done, fault_Cleared;
  logic [2:0] fault_Code;
  logic [3:0] rinse_Count, state;
  int n_checks = 0, n_fail = 0;
  logic [23:0] exp_q[$];
  bit mon_en = 0;
  int m_ph, m_el, m_saved, m_code, m_rc;
  bit m_ret, m_done, m_clr;

  wm_cycle_controller #(
    .TIMER_W(8), .FILL_TIMEOUT(FILL_T), .HEAT_TIMEOUT(HEAT_T), .WASH_CYCLES(WASH_T),
    .RINSE_CYCLES(RINSE_T), .NUM_RINSES(NRINSE), .SPIN_CYCLES(SPIN_T), .FAULT_HOLD(HOLD)
  ) dut (
    .clock(clock), .reset(reset), .sig_Coin(sig_Coin), .sig_Cancel(sig_Cancel),
    .sig_Lid_Closed(sig_Lid_Closed), .sig_Full(sig_Full), .sig_Temperature(sig_Temperature),
    .sig_Out_Of_Balance(sig_Out_Of_Balance), .sig_Motor_Failure(sig_Motor_Failure),
    .sig_Fault_Ack(sig_Fault_Ack), .start(start), .ready(ready),
    .fill_Water_Operation(fill_Water_Operation), .heat_Water_Operation(heat_Water_Operation),
    .wash_Operation(wash_Operation), .rinse_Operation(rinse_Operation),
    .spin_Operation(spin_Operation), .fault(fault), .paused(paused),
    .water_Intake(water_Intake), .coin_Return(coin_Return), .cycle_Done(cycle_Done),
    .fault_Cleared(fault_Cleared), .fault_Code(fault_Code), .rinse_Count(rinse_Count),
    .state(state)
  );

  always #5 clock = ~clock;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic logic [23:0] dut_vec();
    return {start, ready, fill_Water_Operation, heat_Water_Operation, wash_Operation,
            rinse_Operation, spin_Operation, fault, paused, water_Intake,
            coin_Return, cycle_Done, fault_Cleared, fault_Code, rinse_Count, state};
  endfunction

  function automatic logic [23:0] model_vec();
    return {m_ph == 0, m_ph == 1, m_ph == 2, m_ph == 3, m_ph == 4, m_ph == 5, m_ph == 6,
            m_ph == 8, m_ph == 7, (m_ph == 2 || m_ph == 5), m_ret, m_done, m_clr,
            3'(m_code), 4'(m_rc), 4'(m_ph)};
  endfunction

  function automatic int dur(int ph);
    case (ph)
      2: return FILL_T;
      3: return HEAT_T;
      4: return WASH_T;
      5: return RINSE_T;
      6: return SPIN_T;
      default: return HOLD;
    endcase
  endfunction

  task automatic model_reset();
    m_ph = 0; m_el = 0; m_saved = 0; m_code = 0; m_rc = 0;
    m_ret = 0; m_done = 0; m_clr = 0;
  endtask

  // phases 0..8 as numbered; m_el = active cycles already spent in the current phase
  task automatic step(input bit coin = 0, cancel = 0, lid = 0, full = 0, temp = 0,
                      imb = 0, mot = 0, ack = 0);
    bit ex, done_cond;
    int f;
    sig_Coin = coin; sig_Cancel = cancel; sig_Lid_Closed = lid; sig_Full = full;
    sig_Temperature = temp; sig_Out_Of_Balance = imb; sig_Motor_Failure = mot; sig_Fault_Ack = ack;
    m_ret = 0; m_done = 0; m_clr = 0;
    ex = m_el >= dur(m_ph) - 1;
    case (m_ph)
      0: if (coin) m_ph = 1;
      1: if (cancel) begin m_ph = 0; m_ret = 1; end
         else if (lid) begin m_ph = 2; m_rc = 0; m_el = 0; end
      2, 3, 4, 5, 6: begin
        f = 0;
        if (m_ph == 2 && ex) f = 1;
        if (m_ph == 3 && ex) f = 2;
        if (m_ph == 4 && imb) f = 3;
        if (m_ph == 5 && mot) f = 4;
        if (m_ph == 6) f = mot ? 4 : imb ? 3 : 0;
        done_cond = m_ph == 2 ? full : m_ph == 3 ? temp : ex;
        if (f != 0) begin m_ph = 8; m_code = f; m_el = 0; end
        else if (!lid) begin m_saved = m_ph; m_ph = 7; m_el++; end
        else if (done_cond) begin
          if (m_ph == 5) begin m_rc++; m_ph = (m_rc == NRINSE) ? 6 : 5; end
          else if (m_ph == 6) begin m_ph = 1; m_done = 1; end
          else m_ph++;
          m_el = 0;
        end else m_el++;
      end
      7: if (cancel) begin m_ph = 0; m_rc = 0; end
         else if (lid) m_ph = m_saved;
      8: if (ex && ack) begin m_ph = 1; m_clr = 1; m_code = 0; end
         else m_el++;
      default: m_ph = 0;
    endcase
    exp_q.push_back(model_vec());
    @(negedge clock);
  endtask

  // monitor: every clock while enabled, pop the predicted outputs and compare
  always @(posedge clock) if (mon_en) begin
    #1;
    if (exp_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard_empty: got no prediction at %0t", $time);
    end else chk("outputs", 32'(dut_vec()), 32'(exp_q.pop_front()));
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clock);
    chk("reset_outputs", 32'(dut_vec()), 32'h800000);
    reset = 0;
    mon_en = 1;
    // happy path
    step(.coin(1)); chk("to_ready", state, 1);
    step(.lid(1)); chk("to_fill", state, 2);
    step(.lid(1)); step(.lid(1)); step(.lid(1), .full(1)); chk("to_heat", state, 3);
    step(.lid(1)); step(.lid(1), .temp(1)); chk("to_wash", state, 4);
    repeat (9) step(.lid(1)); chk("wash_9", state, 4);
    step(.lid(1)); chk("wash_10", state, 5);
    repeat (4) step(.lid(1)); chk("rinse1_state", state, 5); chk("rinse1_count", rinse_Count, 1);
    repeat (4) step(.lid(1)); chk("rinse2_state", state, 6); chk("rinse2_count", rinse_Count, 2);
    repeat (3) step(.lid(1)); chk("spin_3", state, 6);
    step(.lid(1)); chk("done_state", state, 1); chk("done_pulse", cycle_Done, 1);
    step(); chk("done_pulse_end", cycle_Done, 0);
    // fill timeout and early/late acknowledge
    step(.lid(1));
    repeat (4) step(.lid(1)); chk("fill_4", state, 2);
    step(.lid(1)); chk("fill_to_state", state, 8); chk("fill_to_code", fault_Code, 1);
    step(); step(); step(.ack(1)); chk("early_ack", state, 8);
    repeat (5) step(); chk("fault_hold", state, 8);
    step(.ack(1)); chk("ack_state", state, 1); chk("ack_pulse", fault_Cleared, 1);
    chk("ack_code", fault_Code, 0);
    step(); chk("ack_pulse_end", fault_Cleared, 0);
    // lid pause in WASH, then motor+imbalance in SPIN
    step(.lid(1)); step(.lid(1), .full(1)); step(.lid(1), .temp(1));
    repeat (3) step(.lid(1));
    step(); chk("pause_state", state, 7); chk("pause_flag", paused, 1);
    repeat (5) step(); chk("pause_hold", state, 7);
    step(.lid(1)); chk("resume_state", state, 4); chk("resume_flag", paused, 0);
    repeat (5) step(.lid(1)); chk("resume_wash", state, 4);
    step(.lid(1)); chk("wash_16_wall", state, 5);
    repeat (8) step(.lid(1)); chk("spin_entry", state, 6);
    step(.lid(1), .imb(1), .mot(1)); chk("spin_fault", state, 8); chk("spin_code", fault_Code, 4);
    repeat (8) step(.ack(1)); chk("spin_fault_exit", state, 1);
    // cancel beats lid in READY
    step(.cancel(1), .lid(1)); chk("cancel_state", state, 0); chk("refund", coin_Return, 1);
    step(); chk("refund_end", coin_Return, 0);
    // async reset mid-RINSE
    step(.coin(1)); step(.lid(1)); step(.lid(1), .full(1)); step(.lid(1), .temp(1));
    repeat (15) step(.lid(1)); chk("mid_rinse", state, 5); chk("mid_rinse_count", rinse_Count, 1);
    mon_en = 0;
    #2 reset = 1;
    #1 chk("async_state", state, 0); chk("async_count", rinse_Count, 0); chk("async_start", start, 1);
    model_reset();
    repeat (2) @(negedge clock);
    reset = 0;
    mon_en = 1;
    // biased random traffic
    repeat (2500)
      step(.coin($urandom_range(99) < 60), .cancel($urandom_range(99) < 3),
           .lid($urandom_range(99) < 90), .full($urandom_range(99) < 30),
           .temp($urandom_range(99) < 30), .imb($urandom_range(99) < 2),
           .mot($urandom_range(99) < 2), .ack($urandom_range(99) < 30));
    mon_en = 0;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
